apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB completer with a small control/status register bank, programmable wait states and error responses. It sits on the slave side of the `apb2apb_async` bridge, clocked by the bridge's slave clock, and answers the `s_*` transfers the bridge emits. It is the responder counterpart of the bench-level APB initiator and replaces the tied-off `s_pready`/`s_pslverr` used today.

## Interface
- `BASE_ADDR`, default `32'h0000_1000`: byte address of register 0.
- `NUM_REGS`, default 8: number of 32-bit registers; range 3..16.
- `WAIT_CYCLES`, default 0: extra access-phase cycles before `s_pready`; range 0..15.
- `ID_VALUE`, default `32'hA9B0_0001`: constant returned by register 0.
- `clk_apbs` input 1: clock.
- `rst_apbs` input 1: synchronous, active-high reset.
- `s_psel` input 1: APB select.
- `s_penable` input 1: APB enable (access phase).
- `s_pwrite` input 1: 1 = write.
- `s_paddr` input 32: byte address.
- `s_pwdata` input 32: write data.
- `s_pprot` input 3: protection; accepted, not decoded.
- `s_pstrb` input 4: byte write strobes.
- `hw_status` input 32: live value for register 1.
- `s_prdata` output 32: read data.
- `s_pready` output 1: transfer complete.
- `s_pslverr` output 1: error response.
- `reg_q` output `NUM_REGS*32`: flattened register contents; register 0 holds `ID_VALUE` and register 1 holds `hw_status`.

## Operation
- Register map:
  - Index = (`s_paddr` − `BASE_ADDR`) >> 2.
  - Index 0: ID, read-only.
  - Index 1: STATUS, read-only, reads `hw_status`.
  - Indices 2..`NUM_REGS`−1: read/write, reset value 0.
- FSM states IDLE and ACCESS; wait counter `cnt` is 4 bits.
  - IDLE → ACCESS when `s_psel`=1 and `s_penable`=0 (setup phase); load `cnt` = `WAIT_CYCLES`.
  - In ACCESS with `s_psel`=1 and `cnt`≠0: decrement `cnt`.
  - In ACCESS with `cnt`=0: the transfer completes this cycle; go to IDLE at the next edge.
  - In ACCESS, `s_psel`=0 (protocol abort): go to IDLE; no write, no error.
  - In IDLE, `s_psel`=1 and `s_penable`=1 without a preceding setup: ignored, stay IDLE.
- `s_pready` = (state = ACCESS and `cnt` = 0). It is Moore-decoded from state, with no combinational input path.
- Write commit: at the completing edge, when `s_pwrite`=1, the target is RW and there is no error, update byte i from `s_pwdata` wherever `s_pstrb[i]`=1.
- Read data: `s_prdata` = selected register while `s_pready`=1 and `s_pwrite`=0; 0 otherwise, including on error.
- Error conditions: address out of range, `s_paddr[1:0]`≠0, or a write to index 0 or 1.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `s_pready` 0, `s_pslverr` 0, `s_prdata` 0.
  - RW registers 0.
- Reset mid-transfer: return to IDLE; any pending write is discarded.
- Latency with `WAIT_CYCLES`=N: setup cycle, then N+1 access cycles; `s_pready` is high only in the last access cycle.
- N=0 gives a zero-wait transfer: 2 cycles total.
- Back-to-back transfers: a setup phase in the cycle right after completion is accepted. No idle cycle is required.
- `s_pslverr` is valid only while `s_pready`=1, and is 0 at all other times.
- A write becomes visible on `reg_q` and to reads one cycle after the completing edge.

## Configuration
- Macro `APB_SLAVE_REGS_ERR_EN`.
- Defined: the error conditions assert `s_pslverr` with `s_pready`, and the write is suppressed.
- Undefined:
  - `s_pslverr` is tied to 0.
  - Erroneous writes are silently dropped.
  - Erroneous reads return 0.

## Structure
- Package `apb_slave_regs_pkg` holds:
  - the FSM state enum (IDLE, ACCESS);
  - register index constants (`IDX_ID`=0, `IDX_STATUS`=1, `IDX_RW0`=2);
  - the default `ID_VALUE`.
- One sub-module, `apb_slave_regs_decode`: combinational address-to-index decode producing `idx`, `in_range`, `misaligned` and `read_only`.

## Test plan
- Full-word write, N=0: write `0x1008` = `0x0000A0AF` with strobe `F`, then read `0x1008` → `s_prdata`=`0x0000A0AF`, `s_pslverr`=0, each transfer 2 cycles.
- Partial write: write `0x1008` = `0x00007800` with strobe `4'b0010` after the previous test → read returns `0x000078AF`.
- Read-only and live registers: read `0x1000` → `0xA9B00001`. Set `hw_status`=`0x7895`, read `0x1004` → `0x00007895`. Write `0x1004` → `s_pslverr`=1 (with macro) and the register is unchanged.
- Bad addresses: write `0x1020`, then `0x100A` → `s_pslverr`=1 with macro, 0 without it. `reg_q` is unchanged in both cases.
- Wait states with `WAIT_CYCLES`=2: `s_pready` is high exactly in the 3rd access cycle. Deassert `s_psel` in the 2nd access cycle → abort, FSM returns to IDLE, no write.
- Reset: assert `rst_apbs` during a write's access cycle → next cycle `s_pready`=0 and all RW registers are 0.

Source files
------------

// File: rtl/apb_slave_regs_pkg.sv
// Shared types and constants for the apb_slave_regs register bank.
// Optional error signalling is enabled by defining APB_SLAVE_REGS_ERR_EN.
package apb_slave_regs_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int unsigned IDX_ID     = 0;
  localparam int unsigned IDX_STATUS = 1;
  localparam int unsigned IDX_RW0    = 2;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

endpackage

// File: rtl/apb_slave_regs_decode.sv
// Combinational APB byte-address to register-index decode.
module apb_slave_regs_decode
  import apb_slave_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned NUM_REGS  = 8
) (
  input  logic [31:0] s_paddr,
  output logic [3:0]  idx,
  output logic        in_range,
  output logic        misaligned,
  output logic        read_only
);

  // Word offset wraps for addresses below the base, so they land out of range.
  logic [29:0] word_off;

  assign word_off   = s_paddr[31:2] - BASE_ADDR[31:2];
  assign idx        = word_off[3:0];
  assign in_range   = (word_off < 30'(NUM_REGS));
  assign misaligned = |s_paddr[1:0];
  assign read_only  = in_range && (idx < 4'(IDX_RW0));

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer with ID/STATUS/RW register bank and programmable wait states.
// Define APB_SLAVE_REGS_ERR_EN to report decode errors on s_pslverr.
module apb_slave_regs
  import apb_slave_regs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic                   clk_apbs,
  input  logic                   rst_apbs,
  input  logic                   s_psel,
  input  logic                   s_penable,
  input  logic                   s_pwrite,
  input  logic [31:0]            s_paddr,
  input  logic [31:0]            s_pwdata,
  input  logic [2:0]             s_pprot,
  input  logic [3:0]             s_pstrb,
  input  logic [31:0]            hw_status,
  output logic [31:0]            s_prdata,
  output logic                   s_pready,
  output logic                   s_pslverr,
  output logic [NUM_REGS*32-1:0] reg_q
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx;
  logic        in_range, misaligned, read_only;
  logic        err_any, wr_en;
  logic [31:0] rd_word;
  logic [31:0] regs [NUM_REGS];
  logic        unused_pprot;

  assign unused_pprot = ^s_pprot;

  apb_slave_regs_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .s_paddr    (s_paddr),
    .idx        (idx),
    .in_range   (in_range),
    .misaligned (misaligned),
    .read_only  (read_only)
  );

  always_ff @(posedge clk_apbs) begin
    if (rst_apbs) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s_psel && !s_penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (!s_psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign s_pready = (state_q == ACCESS) && (cnt_q == '0);
  assign err_any  = !in_range || misaligned || (s_pwrite && read_only);
  assign wr_en    = s_pready && s_psel && s_pwrite && !err_any;

`ifdef APB_SLAVE_REGS_ERR_EN
  assign s_pslverr = s_pready && err_any;
`else
  assign s_pslverr = 1'b0;
`endif

  assign regs[IDX_ID]     = ID_VALUE;
  assign regs[IDX_STATUS] = hw_status;

  for (genvar g = IDX_RW0; g < NUM_REGS; g++) begin : g_rw
    logic [31:0] rw_q;

    always_ff @(posedge clk_apbs) begin
      if (rst_apbs) begin
        rw_q <= '0;
      end else if (wr_en && (idx == 4'(g))) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (s_pstrb[b]) rw_q[8*b +: 8] <= s_pwdata[8*b +: 8];
        end
      end
    end

    assign regs[g] = rw_q;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*32 +: 32] = regs[g];
  end

  // Index compare per entry keeps the mux free of out-of-bounds selects.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) rd_word = regs[i];
    end
  end

  assign s_prdata = (s_pready && !s_pwrite && !err_any) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: zero-wait and two-wait instances.
module tb_apb_slave_regs;

`ifdef APB_SLAVE_REGS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic         clk_apbs = 1'b0;
  logic         rst_apbs;
  logic         psel [2];
  logic         penable, pwrite;
  logic [31:0]  paddr, pwdata, hw_status;
  logic [2:0]   pprot;
  logic [3:0]   pstrb;
  logic [31:0]  prdata [2];
  logic         pready [2];
  logic         pslverr [2];
  logic [255:0] regq [2];

  int unsigned  tests = 0;
  int unsigned  failed = 0;
  bit           cmp_en = 1'b0;

  logic [31:0]  m_regs [2][8];
  bit           exp_ready [2];
  bit           exp_err [2];
  logic [31:0]  exp_rdata [2];

  logic [31:0]  last_rdata;
  bit           last_err;
  int unsigned  last_ready_at, last_ready_cnt;

  always #5 clk_apbs = ~clk_apbs;

  apb_slave_regs #(
    .BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_CYCLES(0), .ID_VALUE(ID)
  ) u_dut0 (
    .clk_apbs(clk_apbs), .rst_apbs(rst_apbs), .s_psel(psel[0]), .s_penable(penable),
    .s_pwrite(pwrite), .s_paddr(paddr), .s_pwdata(pwdata), .s_pprot(pprot),
    .s_pstrb(pstrb), .hw_status(hw_status), .s_prdata(prdata[0]),
    .s_pready(pready[0]), .s_pslverr(pslverr[0]), .reg_q(regq[0])
  );

  apb_slave_regs #(
    .BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_CYCLES(2), .ID_VALUE(ID)
  ) u_dut2 (
    .clk_apbs(clk_apbs), .rst_apbs(rst_apbs), .s_psel(psel[1]), .s_penable(penable),
    .s_pwrite(pwrite), .s_paddr(paddr), .s_pwdata(pwdata), .s_pprot(pprot),
    .s_pstrb(pstrb), .hw_status(hw_status), .s_prdata(prdata[1]),
    .s_pready(pready[1]), .s_pslverr(pslverr[1]), .reg_q(regq[1])
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit is_err(input bit wr, input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h1000;
    return (a[1:0] != 2'b00) || (off >= 32'd32) || (wr && off < 32'd8);
  endfunction

  function automatic logic [31:0] model_read(input int unsigned u, input logic [31:0] a);
    int unsigned i;
    i = int'((a - 32'h1000) / 4);
    if (i == 0) return ID;
    if (i == 1) return hw_status;
    return m_regs[u][i];
  endfunction

  function automatic logic [255:0] model_regq(input int unsigned u);
    logic [255:0] v;
    for (int i = 0; i < 8; i++)
      v[i*32 +: 32] = (i == 0) ? ID : (i == 1) ? hw_status : m_regs[u][i];
    return v;
  endfunction

  task automatic model_write(input int unsigned u, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s);
    int unsigned i;
    i = int'((a - 32'h1000) / 4);
    for (int b = 0; b < 4; b++)
      if (s[b]) m_regs[u][i][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic exp_clear();
    for (int u = 0; u < 2; u++) begin
      exp_ready[u] = 1'b0; exp_err[u] = 1'b0; exp_rdata[u] = '0;
    end
  endtask

  task automatic bus_idle();
    psel[0] = 1'b0; psel[1] = 1'b0; penable = 1'b0; exp_clear();
  endtask

  // Cycle-by-cycle checker: every cycle both instances must match the model.
  always @(negedge clk_apbs) begin
    if (cmp_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("pready%0d", u), 256'(pready[u]), 256'(exp_ready[u]));
        check($sformatf("pslverr%0d", u), 256'(pslverr[u]), 256'(exp_err[u]));
        check($sformatf("prdata%0d", u), 256'(prdata[u]), 256'(exp_rdata[u]));
        check($sformatf("reg_q%0d", u), regq[u], model_regq(u));
      end
    end
  end

  // One transfer on instance u; abort_at names an access cycle where psel drops.
  task automatic xfer(input int unsigned u, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int unsigned abort_at, input bit rst_last);
    int unsigned n;
    bit bad;
    n = (u == 0) ? 0 : 2;
    bad = is_err(wr, a);
    last_ready_at = 0; last_ready_cnt = 0; last_err = 1'b0; last_rdata = '0;
    exp_clear();
    psel[u] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk_apbs); #1;
    for (int unsigned j = 1; j <= n + 1; j++) begin
      exp_clear();
      if (j == abort_at) begin
        psel[u] = 1'b0; penable = 1'b0;
        @(posedge clk_apbs); #1;
        bus_idle();
        return;
      end
      penable = 1'b1;
      if (j == n + 1) begin
        exp_ready[u] = 1'b1;
        exp_err[u]   = ERR_EN && bad;
        exp_rdata[u] = (!wr && !bad) ? model_read(u, a) : 32'h0;
        if (rst_last) rst_apbs = 1'b1;
      end
      @(negedge clk_apbs);
      if (pready[u]) begin
        last_ready_cnt++; last_ready_at = j; last_err = pslverr[u]; last_rdata = prdata[u];
      end
      @(posedge clk_apbs); #1;
    end
    if (rst_last) begin
      rst_apbs = 1'b0;
      for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_regs[k][i] = '0;
    end else if (wr && !bad) begin
      model_write(u, a, d, s);
    end
    bus_idle();
  endtask

  task automatic idle(input int unsigned n);
    bus_idle();
    repeat (n) @(posedge clk_apbs);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m_regs[k][i] = '0;
    rst_apbs = 1'b1; pwrite = 1'b0; paddr = '0; pwdata = '0; pprot = 3'b000;
    pstrb = 4'h0; hw_status = '0;
    bus_idle();
    repeat (3) @(posedge clk_apbs);
    #1 rst_apbs = 1'b0;
    @(negedge clk_apbs);
    check("rst_pready", 256'(pready[0]), 256'(0));
    check("rst_pslverr", 256'(pslverr[0]), 256'(0));
    check("rst_prdata", 256'(prdata[1]), 256'(0));
    check("rst_rw_regs", 256'(regq[0][255:64]), 256'(0));
    cmp_en = 1'b1;
    @(posedge clk_apbs); #1;

    // Full-word write then read, zero wait states.
    xfer(0, 1'b1, 32'h1008, 32'h0000_A0AF, 4'hF, 0, 1'b0);
    check("wr_ready_cycle", 256'(last_ready_at), 256'(1));
    xfer(0, 1'b0, 32'h1008, 32'h0, 4'h0, 0, 1'b0);
    check("rd_full", 256'(last_rdata), 256'(32'h0000_A0AF));
    check("rd_full_err", 256'(last_err), 256'(0));
    check("rd_ready_cnt", 256'(last_ready_cnt), 256'(1));

    // Partial byte-lane write.
    xfer(0, 1'b1, 32'h1008, 32'h0000_7800, 4'b0010, 0, 1'b0);
    xfer(0, 1'b0, 32'h1008, 32'h0, 4'h0, 0, 1'b0);
    check("rd_partial", 256'(last_rdata), 256'(32'h0000_78AF));

    // ID, live status and write to a read-only register.
    xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 1'b0);
    check("rd_id", 256'(last_rdata), 256'(32'hA9B0_0001));
    hw_status = 32'h0000_7895;
    xfer(0, 1'b0, 32'h1004, 32'h0, 4'h0, 0, 1'b0);
    check("rd_status", 256'(last_rdata), 256'(32'h0000_7895));
    xfer(0, 1'b1, 32'h1004, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
    check("wr_ro_err", 256'(last_err), 256'(ERR_EN));
    xfer(0, 1'b0, 32'h1004, 32'h0, 4'h0, 0, 1'b0);
    check("rd_status_kept", 256'(last_rdata), 256'(32'h0000_7895));

    // Out-of-range and misaligned writes leave the bank untouched.
    xfer(0, 1'b1, 32'h1020, 32'h1111_1111, 4'hF, 0, 1'b0);
    check("wr_oor_err", 256'(last_err), 256'(ERR_EN));
    xfer(0, 1'b1, 32'h100A, 32'h2222_2222, 4'hF, 0, 1'b0);
    check("wr_mis_err", 256'(last_err), 256'(ERR_EN));
    check("bad_wr_keep", 256'(regq[0][95:64]), 256'(32'h0000_78AF));
    xfer(0, 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, 1'b0);
    check("rd_below_base", 256'(last_rdata), 256'(0));

    // Back-to-back transfers with no idle cycle between them.
    xfer(0, 1'b1, 32'h100C, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
    xfer(0, 1'b1, 32'h101C, 32'h0BAD_BEEF, 4'hF, 0, 1'b0);
    xfer(0, 1'b0, 32'h100C, 32'h0, 4'h0, 0, 1'b0);
    check("b2b_rd0", 256'(last_rdata), 256'(32'hCAFE_F00D));
    xfer(0, 1'b0, 32'h101C, 32'h0, 4'h0, 0, 1'b0);
    check("b2b_rd1", 256'(last_rdata), 256'(32'h0BAD_BEEF));

    // Access phase without a setup phase is ignored.
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h1010;
    pwdata = 32'h5555_5555; pstrb = 4'hF; exp_clear();
    @(posedge clk_apbs); #1;
    idle(2);
    check("stray_nowrite", 256'(regq[0][159:128]), 256'(0));

    // Two wait states: ready only in the third access cycle.
    xfer(1, 1'b1, 32'h1008, 32'h1234_5678, 4'hF, 0, 1'b0);
    check("ws_ready_at", 256'(last_ready_at), 256'(3));
    check("ws_ready_cnt", 256'(last_ready_cnt), 256'(1));
    xfer(1, 1'b0, 32'h1008, 32'h0, 4'h0, 0, 1'b0);
    check("ws_rd", 256'(last_rdata), 256'(32'h1234_5678));
    xfer(1, 1'b1, 32'h100C, 32'h0000_DEAD, 4'hF, 2, 1'b0);
    idle(1);
    xfer(1, 1'b0, 32'h100C, 32'h0, 4'h0, 0, 1'b0);
    check("abort_nowrite", 256'(last_rdata), 256'(0));
    check("abort_then_ok", 256'(last_ready_at), 256'(3));

    // Reset in the completing cycle discards the write and clears the bank.
    xfer(0, 1'b1, 32'h1014, 32'h7777_7777, 4'hF, 0, 1'b1);
    @(negedge clk_apbs);
    check("midrst_pready", 256'(pready[0]), 256'(0));
    check("midrst_rw0", 256'(regq[0][255:64]), 256'(0));
    check("midrst_rw2", 256'(regq[1][255:64]), 256'(0));
    @(posedge clk_apbs); #1;
    xfer(0, 1'b0, 32'h1008, 32'h0, 4'h0, 0, 1'b0);
    check("post_rst_rd", 256'(last_rdata), 256'(0));

    idle(2);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
